// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder/accumulator.
// Mode encodings used on in_mode.
package pipe_adder_pkg;

   localparam logic [1:0] MODE_ADD  = 2'd0;
   localparam logic [1:0] MODE_SAT  = 2'd1;
   localparam logic [1:0] MODE_ACC  = 2'd2;
   localparam logic [1:0] MODE_LOAD = 2'd3;

endpackage

// File: rtl/add_sat_unit.sv
// Combinational unsigned adder with optional clamp to all-ones on carry out.
// ovf reports the carry, which is also exactly the clamp condition.
module add_sat_unit #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sat,
   output logic [WIDTH-1:0] sum,
   output logic             ovf
);

   logic [WIDTH-1:0] raw;
   logic             carry;

   always_comb begin
      {carry, raw} = {1'b0, a} + {1'b0, b};
      sum          = (sat && carry) ? '1 : raw;
      ovf          = carry;
   end

endmodule

// File: rtl/pipe_adder_acc.sv
// Registered add / saturating add / per-channel accumulate / load, with a
// single-entry valid/ready output register and NCH independent accumulators.
module pipe_adder_acc
   import pipe_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NCH   = 4,
   localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [CHW-1:0]   in_ch,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic [CHW-1:0]   out_ch,
   output logic             out_ovf
);

   logic [WIDTH-1:0] acc_q [NCH];

   logic             accept;
   logic [WIDTH-1:0] unit_b;
   logic [WIDTH-1:0] unit_sum;
   logic             unit_ovf;
   logic [WIDTH-1:0] res_sum;
   logic [CHW-1:0]   res_ch;
   logic             res_ovf;
   logic             acc_we;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // ACC reuses the shared adder with the selected accumulator as operand B.
   assign unit_b = (in_mode == MODE_ACC) ? acc_q[in_ch] : in_b;

   add_sat_unit #(
      .WIDTH (WIDTH)
   ) u_add_sat (
      .a   (in_a),
      .b   (unit_b),
      .sat (in_mode == MODE_SAT),
      .sum (unit_sum),
      .ovf (unit_ovf)
   );

   always_comb begin
      res_sum = unit_sum;
      res_ovf = unit_ovf;
      res_ch  = '0;
      acc_we  = 1'b0;
      unique case (in_mode)
         MODE_ADD, MODE_SAT: ;
         MODE_ACC: begin
            res_ch = in_ch;
            acc_we = 1'b1;
         end
         MODE_LOAD: begin
            res_sum = in_a;
            res_ovf = 1'b0;
            res_ch  = in_ch;
            acc_we  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_ch    <= '0;
         out_ovf   <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            acc_q[i] <= '0;
         end
      end else if (accept) begin
         out_valid <= 1'b1;
         out_sum   <= res_sum;
         out_ch    <= res_ch;
         out_ovf   <= res_ovf;
         if (acc_we) begin
            acc_q[in_ch] <= res_sum;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pipe_adder_acc.sv
// Directed self-checking bench for pipe_adder_acc: vector table plus
// hand-written reset, backpressure and mid-stream reset sequences.
module tb_pipe_adder_acc;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned NCH   = 4;
   localparam int unsigned CHW   = 2;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [CHW-1:0]   in_ch;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic [CHW-1:0]   out_ch;
   logic             out_ovf;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [1:0]       mode;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [CHW-1:0]   ch;
      logic [WIDTH-1:0] exp_sum;
      logic [CHW-1:0]   exp_ch;
      logic             exp_ovf;
   } vec_t;

   vec_t vecs [9];

   pipe_adder_acc #(
      .WIDTH (WIDTH),
      .NCH   (NCH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_ch     (in_ch),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_ch    (out_ch),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] m, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [CHW-1:0] ch);
      in_valid = v;
      in_mode  = m;
      in_a     = a;
      in_b     = b;
      in_ch    = ch;
   endtask

   initial begin
      // mode, a, b, ch, exp_sum, exp_ch, exp_ovf
      vecs[0] = '{2'd0, 8'hF0, 8'h20, 2'd3, 8'h10, 2'd0, 1'b1};
      vecs[1] = '{2'd0, 8'h12, 8'h34, 2'd1, 8'h46, 2'd0, 1'b0};
      vecs[2] = '{2'd1, 8'hC8, 8'h64, 2'd2, 8'hFF, 2'd0, 1'b1};
      vecs[3] = '{2'd1, 8'h01, 8'h02, 2'd0, 8'h03, 2'd0, 1'b0};
      vecs[4] = '{2'd3, 8'hFA, 8'h99, 2'd1, 8'hFA, 2'd1, 1'b0};
      vecs[5] = '{2'd2, 8'h03, 8'h77, 2'd1, 8'hFD, 2'd1, 1'b0};
      vecs[6] = '{2'd2, 8'h05, 8'h00, 2'd1, 8'h02, 2'd1, 1'b1};
      vecs[7] = '{2'd2, 8'h00, 8'h11, 2'd0, 8'h00, 2'd0, 1'b0};
      vecs[8] = '{2'd0, 8'hFF, 8'h01, 2'd2, 8'h00, 2'd0, 1'b1};

      // Reset held with a beat offered
      rst       = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 2'd3, 8'h77, 8'h00, 2'd2);
      step();
      step();
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_sum", 32'(out_sum), 32'd0);
      chk("reset out_ovf", 32'(out_ovf), 32'd0);

      rst = 1'b0;
      drive(1'b1, 2'd3, 8'h00, 8'h00, 2'd2);
      step();
      chk("load0 out_valid", 32'(out_valid), 32'd1);
      chk("load0 out_sum", 32'(out_sum), 32'h00);
      chk("load0 out_ch", 32'(out_ch), 32'd2);

      // Back-to-back table, one result per cycle
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].ch);
         #1;
         chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
         step();
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("vec%0d out_sum", i), 32'(out_sum), 32'(vecs[i].exp_sum));
         chk($sformatf("vec%0d out_ch", i), 32'(out_ch), 32'(vecs[i].exp_ch));
         chk($sformatf("vec%0d out_ovf", i), 32'(out_ovf), 32'(vecs[i].exp_ovf));
      end

      // Idle drains the held result
      drive(1'b0, 2'd0, 8'h00, 8'h00, 2'd0);
      step();
      chk("drain out_valid", 32'(out_valid), 32'd0);
      chk("drain hold sum", 32'(out_sum), 32'h00);

      // Backpressure: result held while a new beat waits
      drive(1'b1, 2'd0, 8'hF0, 8'h20, 2'd0);
      step();
      chk("bp first sum", 32'(out_sum), 32'h10);
      out_ready = 1'b0;
      drive(1'b1, 2'd3, 8'h42, 8'h00, 2'd3);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
         step();
         chk($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("bp%0d out_sum", i), 32'(out_sum), 32'h10);
         chk($sformatf("bp%0d out_ch", i), 32'(out_ch), 32'd0);
         chk($sformatf("bp%0d out_ovf", i), 32'(out_ovf), 32'd1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp release in_ready", 32'(in_ready), 32'd1);
      step();
      chk("bp new out_valid", 32'(out_valid), 32'd1);
      chk("bp new out_sum", 32'(out_sum), 32'h42);
      chk("bp new out_ch", 32'(out_ch), 32'd3);
      chk("bp new out_ovf", 32'(out_ovf), 32'd0);
      drive(1'b0, 2'd0, 8'h00, 8'h00, 2'd0);
      step();
      chk("bp no dup", 32'(out_valid), 32'd0);
      chk("bp sum held", 32'(out_sum), 32'h42);

      // Mid-stream reset clears pending result and accumulators
      drive(1'b1, 2'd3, 8'h55, 8'h00, 2'd3);
      step();
      chk("mid load sum", 32'(out_sum), 32'h55);
      out_ready = 1'b0;
      drive(1'b0, 2'd0, 8'h00, 8'h00, 2'd0);
      step();
      chk("mid stalled valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid rst out_valid", 32'(out_valid), 32'd0);
      chk("mid rst out_sum", 32'(out_sum), 32'd0);
      out_ready = 1'b1;
      drive(1'b1, 2'd2, 8'h01, 8'h00, 2'd3);
      step();
      chk("mid acc3 valid", 32'(out_valid), 32'd1);
      chk("mid acc3 sum", 32'(out_sum), 32'h01);
      chk("mid acc3 ch", 32'(out_ch), 32'd3);
      chk("mid acc3 ovf", 32'(out_ovf), 32'd0);
      drive(1'b1, 2'd2, 8'h00, 8'h00, 2'd1);
      step();
      chk("mid acc1 cleared", 32'(out_sum), 32'h00);
      drive(1'b0, 2'd0, 8'h00, 8'h00, 2'd0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
